// File: rtl/mmio_bus_bridge_if.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge_if
// Core data-port bus between a requester (core) and mmio_bus_bridge.
//   req_valid  : request present                  (master -> slave)
//   req_ready  : slave can accept a request       (slave  -> master)
//   req_we     : 1 = write, 0 = read              (master -> slave)
//   req_be     : byte enables for writes          (master -> slave)
//   req_addr   : byte address                     (master -> slave)
//   req_wdata  : write data                       (master -> slave)
//   rsp_valid  : one-cycle response pulse         (slave  -> master)
//   rsp_rdata  : read data, 0 on write responses  (slave  -> master)
// ---------------------------------------------------------------------------
interface mmio_bus_bridge_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_be, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_be, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/mmio_bus_bridge.sv
// ---------------------------------------------------------------------------
// mmio_bus_bridge
// Bridges the core data port onto the shared data RAM and an MMIO page that
// holds N_REG byte-writable output registers, N_UART UART channels (data at
// +0, status at +4, stride 0x10 from page offset 0x400) and a sticky error
// register at page offset 0xFFC. At most one request is outstanding; every
// accepted request produces exactly one rsp_valid pulse.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   bus                 : request/response bus (slave side)
//   o_ram_*/i_ram_rdata : RAM port, read data valid RAM_LAT cycles after en
//   o_reg_q             : output registers, reg i at [32*i +: 32]
//   o_uart_tx_*         : TX push strobe and byte per channel
//   i_uart_tx_full      : TX FIFO full per channel
//   o_uart_rx_ren       : RX pop strobe per channel
//   i_uart_rx_data/present : RX head byte and availability per channel
//   o_err               : sticky bus-error flag
// ---------------------------------------------------------------------------
module mmio_bus_bridge #(
    parameter logic [19:0] MMIO_PAGE = 20'hAAAAA,
    parameter int          N_REG     = 4,
    parameter int          N_UART    = 2,
    parameter int          RAM_LAT   = 1,
    parameter int          RAM_AW    = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    mmio_bus_bridge_if.slave      bus,
    output logic                  o_ram_en,
    output logic [3:0]            o_ram_we,
    output logic [RAM_AW-1:0]     o_ram_addr,
    output logic [31:0]           o_ram_wdata,
    input  logic [31:0]           i_ram_rdata,
    output logic [32*N_REG-1:0]   o_reg_q,
    output logic [N_UART-1:0]     o_uart_tx_wen,
    output logic [8*N_UART-1:0]   o_uart_tx_data,
    input  logic [N_UART-1:0]     i_uart_tx_full,
    output logic [N_UART-1:0]     o_uart_rx_ren,
    input  logic [8*N_UART-1:0]   i_uart_rx_data,
    input  logic [N_UART-1:0]     i_uart_rx_present,
    output logic                  o_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RWAIT = 2'd1,
        S_RSP   = 2'd2
    } state_t;

    // RWAIT spans RAM_LAT cycles; the counter holds the remaining cycles minus one.
    localparam logic [1:0] CNT_INIT = 2'(RAM_LAT - 1);

    state_t              r_state;
    logic                r_ready;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic [1:0]          r_cnt;
    logic [32*N_REG-1:0] r_reg_q;
    logic                r_err;

    logic [19:0] w_page;
    logic [11:0] w_off;
    logic [3:0]  w_reg_idx;
    logic [2:0]  w_uart_idx;
    logic        w_is_ram;
    logic        w_is_mmio;
    logic        w_reg_hit;
    logic        w_uart_data_hit;
    logic        w_uart_stat_hit;
    logic        w_err_hit;
    logic        w_mapped;
    logic        w_accept;
    logic        w_err_set;
    logic        w_err_clr;
    logic        w_sel_full;
    logic        w_sel_present;
    logic [7:0]  w_sel_rxd;
    logic [31:0] w_sel_reg;
    logic [31:0] w_rd_data;
    logic        w_unused;

    // Byte offset bits inside a word play no part in decode.
    assign w_unused = &{1'b0, bus.req_addr[1:0]};

    // Address decode of the presented request.
    always_comb begin
        w_page          = bus.req_addr[31:12];
        w_off           = bus.req_addr[11:0];
        w_reg_idx       = bus.req_addr[5:2];
        w_uart_idx      = bus.req_addr[6:4];
        w_is_ram        = (w_page < MMIO_PAGE);
        w_is_mmio       = (w_page == MMIO_PAGE);
        w_reg_hit       = 1'b0;
        w_uart_data_hit = 1'b0;
        w_uart_stat_hit = 1'b0;
        w_err_hit       = 1'b0;
        if (w_is_mmio) begin
            w_reg_hit = (w_off[11:2] < 10'(N_REG));
            if ((w_off[11:10] == 2'b01) && (w_off[9:4] < 6'(N_UART))) begin
                w_uart_data_hit = (w_off[3:2] == 2'b00);
                w_uart_stat_hit = (w_off[3:2] == 2'b01);
            end else begin
                w_uart_data_hit = 1'b0;
                w_uart_stat_hit = 1'b0;
            end
            w_err_hit = (w_off[11:2] == 10'h3FF);
        end else begin
            w_reg_hit = 1'b0;
        end
        w_mapped = w_is_ram | w_reg_hit | w_uart_data_hit | w_uart_stat_hit | w_err_hit;
    end

    // Per-channel / per-register selection of the addressed resource.
    always_comb begin
        w_sel_full    = 1'b0;
        w_sel_present = 1'b0;
        w_sel_rxd     = 8'h00;
        w_sel_reg     = 32'h0000_0000;
        for (int k = 0; k < N_UART; k++) begin
            if (w_uart_idx == 3'(k)) begin
                w_sel_full    = i_uart_tx_full[k];
                w_sel_present = i_uart_rx_present[k];
                w_sel_rxd     = i_uart_rx_data[8*k +: 8];
            end else begin
                w_sel_full = w_sel_full;
            end
        end
        for (int i = 0; i < N_REG; i++) begin
            if (w_reg_idx == 4'(i)) begin
                w_sel_reg = r_reg_q[32*i +: 32];
            end else begin
                w_sel_reg = w_sel_reg;
            end
        end
    end

    // Accept qualification and error set/clear conditions.
    always_comb begin
        w_accept  = bus.req_valid & r_ready;
        // A write into a full TX FIFO is dropped and flagged like a bus error.
        w_err_set = w_accept & (~w_mapped | (bus.req_we & w_uart_data_hit & w_sel_full));
        w_err_clr = w_accept & ~bus.req_we & w_err_hit;
    end

    // Accept-cycle strobes toward the RAM and the UART channels.
    always_comb begin
        o_ram_en      = w_accept & w_is_ram;
        o_ram_addr    = bus.req_addr[RAM_AW+1:2];
        o_ram_wdata   = bus.req_wdata;
        o_ram_we      = 4'b0000;
        o_uart_tx_wen = '0;
        o_uart_rx_ren = '0;
        if (w_accept & w_is_ram & bus.req_we) begin
            o_ram_we = bus.req_be;
        end else begin
            o_ram_we = 4'b0000;
        end
        for (int k = 0; k < N_UART; k++) begin
            if (w_accept & w_uart_data_hit & (w_uart_idx == 3'(k))) begin
                o_uart_tx_wen[k] = bus.req_we & ~i_uart_tx_full[k];
                o_uart_rx_ren[k] = ~bus.req_we & i_uart_rx_present[k];
            end else begin
                o_uart_tx_wen[k] = 1'b0;
                o_uart_rx_ren[k] = 1'b0;
            end
        end
    end

    assign o_uart_tx_data = {N_UART{bus.req_wdata[7:0]}};

    // Response data for every non-RAM-read access, sampled at accept.
    always_comb begin
        w_rd_data = 32'h0000_0000;
        if (bus.req_we) begin
            w_rd_data = 32'h0000_0000;
        end else if (w_reg_hit) begin
            w_rd_data = w_sel_reg;
        end else if (w_uart_data_hit) begin
            w_rd_data = w_sel_present ? {24'h00_0000, w_sel_rxd} : 32'h0000_0000;
        end else if (w_uart_stat_hit) begin
            w_rd_data = {30'h0000_0000, w_sel_full, w_sel_present};
        end else if (w_err_hit) begin
            w_rd_data = {31'h0000_0000, r_err};
        end else begin
            w_rd_data = 32'h0000_0000;
        end
    end

    // Request/response FSM with registered ready and response outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'h0000_0000;
            r_cnt       <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (w_is_ram & ~bus.req_we) begin
                            r_state     <= S_RWAIT;
                            r_cnt       <= CNT_INIT;
                            r_rsp_valid <= 1'b0;
                        end else begin
                            r_state     <= S_RSP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_rd_data;
                        end
                    end else begin
                        r_ready     <= 1'b1;
                        r_rsp_valid <= 1'b0;
                    end
                end
                S_RWAIT: begin
                    if (r_cnt == 2'd0) begin
                        r_state     <= S_RSP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= i_ram_rdata;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RSP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'h0000_0000;
                    r_ready     <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_rdata <= 32'h0000_0000;
                    r_ready     <= 1'b0;
                end
            endcase
        end
    end

    // Output registers: byte lanes with req_be set update at the accept edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reg_q <= '0;
        end else if (w_accept & bus.req_we & w_reg_hit) begin
            for (int i = 0; i < N_REG; i++) begin
                for (int b = 0; b < 4; b++) begin
                    if ((w_reg_idx == 4'(i)) && bus.req_be[b]) begin
                        r_reg_q[32*i + 8*b +: 8] <= bus.req_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    // Sticky error flag; a new error beats the read-to-clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (w_err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign o_reg_q       = r_reg_q;
    assign o_err         = r_err;

endmodule
